ex_muldiv_unit: RTL
===================

Name: ex_muldiv_unit

Overview:
- Execute-stage consumer of the ID/EX pipeline register outputs. Implements the RV32M multiply/divide instructions with an iterative shift-add/shift-subtract datapath.
- Accepts an op when the latched funct field decodes as M-extension. Holds the pipeline through `stall_o` until the result is ready.
- Returns the result with its destination register for the EX/MEM register write.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width (must hold XLEN).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  ID/EX holds a candidate instruction this cycle.
- funct_i  in  10  {funct7, funct3} from ID/EX.
- RS1Data_i  in  XLEN  operand A.
- RS2Data_i  in  XLEN  operand B.
- Rd_Addr_i  in  5  destination register.
- kill_i  in  1  flush; abort any op in flight.
- stall_o  out  1  freeze PC, IF/ID and ID/EX (drives their enable low).
- done_o  out  1  one-cycle pulse; result valid.
- result_o  out  XLEN  final result.
- Rd_Addr_o  out  5  destination of the completed op.
- busy_o  out  1  state != IDLE.

Behaviour:
- Issue:
  - An op is issued when valid_i=1, funct7=7'b0000001 and state is IDLE.
  - Any other funct7 is ignored; outputs are unchanged.
- States:
  - IDLE: on issue, latch operands, funct3 and Rd. Go to CALC, or to DONE for a special case.
  - CALC: one iteration per cycle. After XLEN iterations, go to DONE.
  - DONE: pulse done_o for one cycle, then go to IDLE.
- stall_o:
  - Combinational: (IDLE and issue) or CALC.
  - Low in DONE, so the pipeline advances on the cycle result_o is valid.
- Latency: op issued at cycle 0 produces done_o at cycle XLEN+1 (33 by default).
- Multiply (funct3 = 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU):
  - Operands are sign- or zero-extended per op, and the multiply runs on magnitudes.
  - The 2·XLEN product is negated at the end if the signs differ.
  - MUL returns product[XLEN-1:0]; the others return product[2XLEN-1:XLEN].
- Divide (funct3 = 100 DIV, 101 DIVU, 110 REM, 111 REMU):
  - Restoring division on magnitudes.
  - Quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
- Special cases (go directly IDLE→DONE, latency 1):
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return A.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- kill_i:
  - In CALC or DONE: go to IDLE next cycle; no done_o; stall_o drops immediately.
  - In IDLE with issue pending: no issue.
- valid_i in any state other than IDLE is ignored (the pipeline is frozen anyway).
- Reset:
  - State = IDLE; stall_o=0, done_o=0, busy_o=0, result_o=0, Rd_Addr_o=0; counter=0.
  - Reset mid-operation discards the op.
- result_o and Rd_Addr_o hold their last value after DONE until the next completion.

Optional Feature:
- MULDIV_FAST_MUL_EN
  - Defined: multiply ops use a single-cycle combinational 2·XLEN product. IDLE→DONE directly, done_o at cycle 1, stall_o high only in the issue cycle. Divide timing is unchanged.
  - Undefined: every multiply is iterative (XLEN+1 cycles).

Decomposition:
- Package muldiv_pkg:
  - FUNCT7_MULDIV constant.
  - funct3 op encodings (OP_MUL..OP_REMU).
  - state enum {IDLE, CALC, DONE}.
- Sub-module muldiv_div_iter: one restoring-division step (remainder/quotient shift, subtract, select). It is instantiated once in the top; the FSM, sign handling and multiply stay in ex_muldiv_unit.

Test Plan:
- MUL A=7, B=-3 (0xFFFFFFFD) -> stall_o high 33 cycles; done_o at cycle 33; result_o=0xFFFFFFEB.
- MULHU A=0xFFFFFFFF, B=0xFFFFFFFF -> result_o=0xFFFFFFFE; MULH with the same operands -> 0x00000000.
- DIV A=-20, B=6 -> result_o=0xFFFFFFFD (-3); REM with the same operands -> 0xFFFFFFFE (-2); Rd_Addr_o equals the issued Rd.
- DIVU A=5, B=0 -> done_o at cycle 1, result 0xFFFFFFFF. REM A=0x80000000, B=0xFFFFFFFF -> result 0, latency 1.
- kill_i at CALC cycle 10 -> no done_o; stall_o=0 next cycle; a new MUL issued afterwards completes correctly.
- rst_i asserted mid-CALC (asynchronous, between edges) -> all outputs 0 immediately; busy_o=0. An op with funct7=0 is never accepted (stall_o stays 0).

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the RV32M multiply/divide execute unit.
package muldiv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_div_iter.sv
// One restoring-division step on unsigned magnitudes.
// The partial remainder takes the next dividend bit; the divisor is
// subtracted when it fits, and the outcome becomes the new quotient bit.
module muldiv_div_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;
    logic          w_fits;

    // The remainder is always below the divisor, so the shifted value fits in
    // XLEN+1 bits and the MSB of the difference acts as the borrow.
    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    assign w_fits  = ~w_diff[XLEN];

    assign o_rem = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign o_quo = {i_quo[XLEN-2:0], w_fits};

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide unit for the execute stage.
// Iterative shift-add multiply and restoring divide on operand magnitudes,
// one bit per cycle, with the sign applied once at the end.
// Build option MULDIV_FAST_MUL_EN: multiplies complete from a single-cycle
// combinational product instead of iterating; divide timing is unchanged.
//
// state | meaning
// IDLE  | waiting for an M-extension op from ID/EX
// CALC  | one multiply/divide iteration per cycle, counter runs down
// DONE  | result valid, done_o pulses, pipeline released
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [9:0]      funct_i,
    input  logic [XLEN-1:0] RS1Data_i,
    input  logic [XLEN-1:0] RS2Data_i,
    input  logic [4:0]      Rd_Addr_i,
    input  logic            kill_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      Rd_Addr_o,
    output logic            busy_o
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_funct3;
    logic [4:0]          r_rd;
    logic [4:0]          r_rd_hold;
    logic                r_neg;
    logic [XLEN-1:0]     r_opnd;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_final;
    logic [XLEN-1:0]     r_result_hold;

    logic [2:0]          w_funct3;
    logic                w_issue;
    logic                w_is_div;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic                w_neg_issue;
    logic                w_div_zero;
    logic                w_div_ovf;
    logic                w_special;
    logic [XLEN-1:0]     w_special_res;
    logic                w_fast;
    logic [2*XLEN-1:0]   w_fast_prod;
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN-1:0]     w_div_rem;
    logic [XLEN-1:0]     w_div_quo;
    logic [2*XLEN-1:0]   w_acc_next;
    logic                w_last;

    // Applies the sign and picks the requested half. For multiply the
    // accumulator is the full product; for divide it is {remainder, quotient}.
    function automatic logic [XLEN-1:0] f_finalize(input logic [2:0]        f3,
                                                   input logic              neg,
                                                   input logic [2*XLEN-1:0] acc);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   v;
        p = '0;
        if (!f3[2]) begin
            p = neg ? -acc : acc;
            v = (f3 == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
        end else begin
            v = f3[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
            if (neg) v = -v;
        end
        return v;
    endfunction

    assign w_funct3 = funct_i[2:0];
    assign w_is_div = w_funct3[2];
    assign w_issue  = valid_i && (funct_i[9:3] == FUNCT7_MULDIV) &&
                      (r_state == IDLE) && !kill_i;

    // Operand signedness per op; MULHSU treats only rs1 as signed.
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (w_funct3)
            OP_MUL, OP_MULH: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            OP_MULHSU: w_a_signed = 1'b1;
            OP_DIV, OP_REM: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            OP_MULHU, OP_DIVU, OP_REMU: begin
                w_a_signed = 1'b0;
                w_b_signed = 1'b0;
            end
            default: begin
                w_a_signed = 1'b0;
                w_b_signed = 1'b0;
            end
        endcase
    end

    assign w_a_neg = w_a_signed & RS1Data_i[XLEN-1];
    assign w_b_neg = w_b_signed & RS2Data_i[XLEN-1];
    assign w_a_mag = w_a_neg ? -RS1Data_i : RS1Data_i;
    assign w_b_mag = w_b_neg ? -RS2Data_i : RS2Data_i;

    // Remainder follows the dividend sign; everything else uses the xor.
    assign w_neg_issue = (w_is_div && w_funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_div_zero = w_is_div && (RS2Data_i == '0);
    assign w_div_ovf  = w_is_div && w_a_signed &&
                        (RS1Data_i == {1'b1, {(XLEN-1){1'b0}}}) && (RS2Data_i == '1);
    assign w_special  = w_div_zero || w_div_ovf;
    assign w_special_res = w_div_zero ? (w_funct3[1] ? RS1Data_i : '1)
                                      : (w_funct3[1] ? '0 : RS1Data_i);

`ifdef MULDIV_FAST_MUL_EN
    assign w_fast      = !w_is_div;
    assign w_fast_prod = {{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag};
`else
    assign w_fast      = 1'b0;
    assign w_fast_prod = '0;
`endif

    // Multiply step: add the multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole accumulator right by one.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                        (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    muldiv_div_iter #(.XLEN(XLEN)) u_div_iter (
        .i_rem     (r_acc[2*XLEN-1:XLEN]),
        .i_quo     (r_acc[XLEN-1:0]),
        .i_divisor (r_opnd),
        .o_rem     (w_div_rem),
        .o_quo     (w_div_quo)
    );

    assign w_acc_next = r_funct3[2] ? {w_div_rem, w_div_quo} : w_mul_next;
    assign w_last     = (r_cnt == CNT_W'(1));

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        stall_o     = 1'b0;
        done_o      = 1'b0;
        busy_o      = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                stall_o = w_issue;
                if (w_issue) w_state_nxt = (w_special || w_fast) ? DONE : CALC;
            end
            CALC: begin
                stall_o = !kill_i;
                if (kill_i)      w_state_nxt = IDLE;
                else if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                done_o      = !kill_i;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        result_o  = done_o ? r_final : r_result_hold;
        Rd_Addr_o = done_o ? r_rd    : r_rd_hold;
    end

    // Operand capture on issue, then one iteration per CALC cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt    <= '0;
            r_funct3 <= '0;
            r_rd     <= '0;
            r_neg    <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_final  <= '0;
        end else if (r_state == IDLE) begin
            if (w_issue) begin
                r_funct3 <= w_funct3;
                r_rd     <= Rd_Addr_i;
                r_neg    <= w_neg_issue;
                r_cnt    <= CNT_W'(XLEN);
                r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
                r_acc    <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                if (w_special)   r_final <= w_special_res;
                else if (w_fast) r_final <= f_finalize(w_funct3, w_neg_issue, w_fast_prod);
            end
        end else if (r_state == CALC) begin
            if (kill_i) begin
                r_cnt <= '0;
            end else begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt - CNT_W'(1);
                if (w_last) r_final <= f_finalize(r_funct3, r_neg, w_acc_next);
            end
        end
    end

    // Completed result and destination persist until the next completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_result_hold <= '0;
            r_rd_hold     <= '0;
        end else if (done_o) begin
            r_result_hold <= r_final;
            r_rd_hold     <= r_rd;
        end
    end

endmodule
